// File: rtl/vga_pkg.sv
// Shared VGA constants: visible geometry, coordinate width and the 12-bit palette.
package vga_pkg;
  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned COORD_W   = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12;

  localparam rgb12 COL_BLACK = rgb12'(12'h000);
  localparam rgb12 COL_WHITE = rgb12'(12'hFFF);
  localparam rgb12 COL_RED   = rgb12'(12'hF00);
  localparam rgb12 COL_BG    = rgb12'(12'h004);
endpackage

// File: rtl/ball_motion.sv
// Ball position, direction and bounce counter; advances once per frame tick.
module ball_motion
  import vga_pkg::*;
#(
  parameter int unsigned BORDER     = 8,
  parameter int unsigned BALL_SIZE  = 16,
  parameter int unsigned BALL_SPEED = 2,
  parameter int unsigned BALL_X0    = 320,
  parameter int unsigned BALL_Y0    = 240
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               pause,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [7:0]         bounce_cnt
);
  localparam int unsigned SUM_W = COORD_W + 1;
  localparam logic [SUM_W-1:0]   REACH   = SUM_W'(BALL_SIZE + BALL_SPEED);
  localparam logic [SUM_W-1:0]   LO_EDGE = SUM_W'(BORDER + BALL_SPEED);
  localparam logic [SUM_W-1:0]   X_HI    = SUM_W'(H_DISPLAY - BORDER);
  localparam logic [SUM_W-1:0]   Y_HI    = SUM_W'(V_DISPLAY - BORDER);
  localparam logic [COORD_W-1:0] POS_MIN = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(H_DISPLAY - BORDER - BALL_SIZE);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(V_DISPLAY - BORDER - BALL_SIZE);
  localparam logic [COORD_W-1:0] STEP    = COORD_W'(BALL_SPEED);

  typedef struct packed {
    logic               bounce;
    logic               neg;
    logic [COORD_W-1:0] pos;
  } axis_t;

  // One axis: step, or clamp against the wall and reverse when the step would reach it.
  function automatic axis_t axis_next(input logic [COORD_W-1:0] pos, input logic neg,
                                      input logic [SUM_W-1:0] hi,
                                      input logic [COORD_W-1:0] pos_max);
    axis_t a;
    a.bounce = 1'b0;
    a.neg    = neg;
    a.pos    = pos;
    if (!neg) begin
      if (SUM_W'(pos) + REACH >= hi) begin
        a.pos    = pos_max;
        a.neg    = 1'b1;
        a.bounce = 1'b1;
      end else begin
        a.pos = pos + STEP;
      end
    end else begin
      if (SUM_W'(pos) <= LO_EDGE) begin
        a.pos    = POS_MIN;
        a.neg    = 1'b0;
        a.bounce = 1'b1;
      end else begin
        a.pos = pos - STEP;
      end
    end
    return a;
  endfunction

  logic  dx_neg;
  logic  dy_neg;
  axis_t x_nxt;
  axis_t y_nxt;

  always_comb begin
    x_nxt = axis_next(ball_x, dx_neg, X_HI, X_MAX);
    y_nxt = axis_next(ball_y, dy_neg, Y_HI, Y_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ball_x     <= COORD_W'(BALL_X0);
      ball_y     <= COORD_W'(BALL_Y0);
      dx_neg     <= 1'b0;
      dy_neg     <= 1'b0;
      bounce_cnt <= '0;
    end else if (frame_tick && !pause) begin
      ball_x     <= x_nxt.pos;
      dx_neg     <= x_nxt.neg;
      ball_y     <= y_nxt.pos;
      dy_neg     <= y_nxt.neg;
      bounce_cnt <= bounce_cnt + 8'(x_nxt.bounce) + 8'(y_nxt.bounce);
    end
  end
endmodule

// File: rtl/vga_ball_renderer.sv
// Two-stage pixel pipeline: border, background and bouncing ball, with syncs kept aligned to RGB.
module vga_ball_renderer
  import vga_pkg::*;
#(
  parameter int unsigned BORDER     = 8,
  parameter int unsigned BALL_SIZE  = 16,
  parameter int unsigned BALL_SPEED = 2,
  parameter int unsigned BALL_X0    = 320,
  parameter int unsigned BALL_Y0    = 240
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pix_en,
  input  logic [9:0]   x,
  input  logic [9:0]   y,
  input  logic         video_on,
  input  logic         hsync_in,
  input  logic         vsync_in,
  input  logic         pause,
  output logic [3:0]   vga_r,
  output logic [3:0]   vga_g,
  output logic [3:0]   vga_b,
  output logic         hsync_out,
  output logic         vsync_out,
  output logic [7:0]   bounce_cnt
);
  localparam int unsigned SUM_W = COORD_W + 1;

  logic [COORD_W-1:0] s1_x;
  logic [COORD_W-1:0] s1_y;
  logic               s1_video_on;
  logic               s1_hsync;
  logic               s1_vsync;
  logic [COORD_W-1:0] ball_x;
  logic [COORD_W-1:0] ball_y;
  logic               frame_tick;
  logic               ball_hit_c;
  logic               border_c;
  rgb12               colour_c;

  // First blanking line, first pixel: ball moves here so a frame never tears.
  assign frame_tick = pix_en && (x == '0) && (y == COORD_W'(V_DISPLAY));

  ball_motion #(
    .BORDER    (BORDER),
    .BALL_SIZE (BALL_SIZE),
    .BALL_SPEED(BALL_SPEED),
    .BALL_X0   (BALL_X0),
    .BALL_Y0   (BALL_Y0)
  ) u_motion (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .pause     (pause),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .bounce_cnt(bounce_cnt)
  );

  assign ball_hit_c = (s1_x >= ball_x) && (s1_y >= ball_y)
                   && (SUM_W'(s1_x) <= SUM_W'(ball_x) + SUM_W'(BALL_SIZE - 1))
                   && (SUM_W'(s1_y) <= SUM_W'(ball_y) + SUM_W'(BALL_SIZE - 1));

  assign border_c = (s1_x < COORD_W'(BORDER)) || (s1_x >= COORD_W'(H_DISPLAY - BORDER))
                 || (s1_y < COORD_W'(BORDER)) || (s1_y >= COORD_W'(V_DISPLAY - BORDER));

  always_comb begin
    colour_c = COL_BLACK;
    if (s1_video_on) begin
      if (ball_hit_c)    colour_c = COL_RED;
      else if (border_c) colour_c = COL_WHITE;
      else               colour_c = COL_BG;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_x        <= '0;
      s1_y        <= '0;
      s1_video_on <= 1'b0;
      s1_hsync    <= 1'b0;
      s1_vsync    <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
    end else if (pix_en) begin
      s1_x        <= x;
      s1_y        <= y;
      s1_video_on <= video_on;
      s1_hsync    <= hsync_in;
      s1_vsync    <= vsync_in;
      vga_r       <= colour_c.r;
      vga_g       <= colour_c.g;
      vga_b       <= colour_c.b;
      hsync_out   <= s1_hsync;
      vsync_out   <= s1_vsync;
    end
  end
endmodule

// File: tb/tb_vga_ball_renderer.sv
// Randomised scoreboard bench for vga_ball_renderer against a plain-arithmetic scene model.
module tb_vga_ball_renderer;
  localparam int H = 640, V = 480, BRD = 8, SZ = 16, SPD = 2;

  logic       clk = 1'b0;
  logic       reset, pix_en, video_on, hsync_in, vsync_in, pause, pause_req;
  logic [9:0] x, y;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       hsync_out, vsync_out;
  logic [7:0] bounce_cnt;

  typedef struct packed { logic [11:0] rgb; logic hs; logic vs; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0, miscompares = 0;
  int   bx, by, ddx, ddy, cnt;

  always #5 clk = ~clk;

  vga_ball_renderer dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .bounce_cnt(bounce_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scene: ball square wins over border frame, which wins over background.
  function automatic logic [11:0] model_colour(input int px, input int py, input bit von);
    if (!von) return 12'h000;
    if (px >= bx && px < bx + SZ && py >= by && py < by + SZ) return 12'hF00;
    if (px < BRD || px >= H - BRD || py < BRD || py >= V - BRD) return 12'hFFF;
    return 12'h004;
  endfunction

  task automatic model_axis(inout int pos, inout int dir, input int far_wall, inout int nb);
    if (dir > 0 && pos + SZ + SPD >= far_wall) begin
      pos = far_wall - SZ; dir = -1; nb++;
    end else if (dir < 0 && pos <= BRD + SPD) begin
      pos = BRD; dir = 1; nb++;
    end else begin
      pos = pos + dir * SPD;
    end
  endtask

  task automatic model_tick();
    int nb = 0;
    if (pause === 1'b1) return;
    model_axis(bx, ddx, H - BRD, nb);
    model_axis(by, ddy, V - BRD, nb);
    cnt = (cnt + nb) % 256;
  endtask

  // After reset the pipeline holds zeros, so the first strobe shows black with syncs low.
  task automatic model_reset();
    bx = 320; by = 240; ddx = 1; ddy = 1; cnt = 0;
    exp_q.delete();
    exp_q.push_back(exp_t'(14'h0));
  endtask

  task automatic drive(input int px, input int py, input bit pe, input bit hs, input bit vs);
    exp_t e;
    @(negedge clk);
    x = 10'(px); y = 10'(py); video_on = (px < H && py < V);
    hsync_in = hs; vsync_in = vs; pix_en = pe; pause = pause_req;
    @(posedge clk);
    if (pe) begin
      if (px == 0 && py == V) model_tick();
      e.rgb = model_colour(px, py, (px < H && py < V));
      e.hs  = hs;
      e.vs  = vs;
      exp_q.push_back(e);
    end
  endtask

  // Directed pixel probe: output two strobes after presenting (px,py).
  task automatic probe(input string name, input int px, input int py, input logic [11:0] req);
    drive(px, py, 1, 1, 0);
    drive(0, 0, 1, 0, 1);
    #1;
    check({name, "_rgb"}, {vga_r, vga_g, vga_b}, req);
    check({name, "_hs"}, hsync_out, 1);
    check({name, "_vs"}, vsync_out, 0);
  endtask

  // Monitor: each strobe retires the entry issued one strobe earlier.
  always @(posedge clk) begin
    if (pix_en === 1'b1 && reset === 1'b1) begin
      #1;
      if (exp_q.size() >= 2) begin
        mon_e = exp_q.pop_front();
        check("rgb", {vga_r, vga_g, vga_b}, mon_e.rgb);
        check("hsync_out", hsync_out, mon_e.hs);
        check("vsync_out", vsync_out, mon_e.vs);
        check("bounce_cnt", bounce_cnt, cnt);
      end
    end
  end

  initial begin
    logic [14:0] held;
    int px, py, r;
    reset = 1'b0; pix_en = 1'b0; x = '0; y = '0; video_on = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; pause = 1'b1; pause_req = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("rst_hs", hsync_out, 0);
    check("rst_vs", vsync_out, 0);
    check("rst_cnt", bounce_cnt, 0);
    reset = 1'b1;

    // Static scene while paused, including a paused frame tick.
    probe("origin", 320, 240, 12'hF00);
    probe("corner00", 0, 0, 12'hFFF);
    probe("bg2020", 20, 20, 12'h004);
    probe("ball_in", 327, 247, 12'hF00);
    probe("ball_br", 335, 255, 12'hF00);
    probe("ball_right", 336, 240, 12'h004);
    probe("blank", 700, 100, 12'h000);
    probe("xedge_in", 631, 100, 12'h004);
    probe("xedge_brd", 632, 100, 12'hFFF);
    probe("yedge_in", 100, 471, 12'h004);
    probe("yedge_brd", 100, 472, 12'hFFF);
    drive(0, V, 1, 0, 1);
    probe("paused", 320, 240, 12'hF00);

    // Motion: 10 ticks, then walk to the right wall.
    pause_req = 1'b0;
    repeat (10) drive(0, V, 1, 0, 1);
    probe("t10_hit", 340, 260, 12'hF00);
    probe("t10_miss", 339, 260, 12'h004);
    repeat (137) drive(0, V, 1, 0, 1);
    probe("t147_hit", 614, 378, 12'hF00);
    probe("t147_miss", 613, 378, 12'h004);
    drive(0, V, 1, 0, 1);
    probe("t148_hit", 616, 376, 12'hF00);
    probe("t148_far", 631, 391, 12'hF00);
    probe("t148_brd", 632, 391, 12'hFFF);
    check("t148_cnt", bounce_cnt, 2);
    drive(0, V, 1, 0, 1);
    probe("t149_hit", 614, 374, 12'hF00);
    probe("t149_miss", 630, 374, 12'h004);

    // Randomised mix of pixels, ticks, pause and gaps in pix_en.
    for (int i = 0; i < 3000; i++) begin
      pause_req = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 5);
      if (r == 0) begin
        px = 0; py = V;
      end else if (r <= 2) begin
        px = bx - 4 + $urandom_range(0, 23); py = by - 4 + $urandom_range(0, 23);
      end else begin
        px = $urandom_range(0, 799); py = $urandom_range(0, 524);
      end
      drive(px, py, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // pix_en low: outputs hold and a presented tick coordinate is ignored.
    pause_req = 1'b0;
    drive(300, 200, 1, 1, 1);
    #1 held = {vga_r, vga_g, vga_b, hsync_out, vsync_out};
    repeat (50) drive(0, V, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    #1;
    check("hold_out", {vga_r, vga_g, vga_b, hsync_out, vsync_out}, held);
    check("hold_cnt", bounce_cnt, cnt);

    // Long run of ticks: bounce_cnt passes 255 and wraps.
    repeat (36000) drive(0, V, 1, 0, 0);

    // Asynchronous reset mid-stream, then the ball is back at its start.
    drive(330, 250, 1, 1, 1);
    @(negedge clk);
    pix_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mrst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("mrst_hs", hsync_out, 0);
    check("mrst_vs", vsync_out, 0);
    check("mrst_cnt", bounce_cnt, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    probe("post_rst", 320, 240, 12'hF00);
    probe("post_rst_miss", 319, 240, 12'h004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
